// File: rtl/dac_spi_tx_pkg.sv
// Shared constants for the DAC SPI transmitter: DAC/frame geometry, FSM encodings
// and the helper that builds a frame word from a DAC code.
package dac_defs;

  localparam int DAC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int DAC_MID    = 2048;
  localparam int DAC_MAX    = (1 << DAC_BITS) - 1;

  typedef logic [DAC_BITS-1:0]   dac_code_t;
  typedef logic [FRAME_BITS-1:0] frame_word_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Upper nibble of the frame carries the DAC's control bits, all zero here.
  function automatic frame_word_t frame_word(input dac_code_t code);
    return {{(FRAME_BITS-DAC_BITS){1'b0}}, code};
  endfunction

endpackage

// File: rtl/dac_code_conv.sv
// Signed fixed-point sample to 12-bit offset-binary DAC code.
// DAC_SAT_EN defined: clamp to [0, 4095]; undefined: wrap modulo 4096.
module dac_code_conv
  import dac_defs::*;
#(
  parameter int DATA_W = 25,
  parameter int FRAC_W = 16
) (
  input  logic [DATA_W-1:0] i_y,
  output dac_code_t         o_code
);

  localparam int SHIFT = FRAC_W - (DAC_BITS - 1);

  logic signed [DATA_W:0] w_ext;
  logic signed [DATA_W:0] w_c;

  // One guard bit so adding the mid-scale offset cannot overflow.
  assign w_ext = $signed({i_y[DATA_W-1], i_y});
  assign w_c   = (w_ext >>> SHIFT) + $signed((DATA_W+1)'(DAC_MID));

`ifdef DAC_SAT_EN
  // NOTE: every path assigns o_code, so no latch is inferred.
  always_comb begin
    if (w_c[DATA_W]) begin
      o_code = '0;
    end else if (w_c > $signed((DATA_W+1)'(DAC_MAX))) begin
      o_code = '1;
    end else begin
      o_code = w_c[DAC_BITS-1:0];
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_c[DATA_W:DAC_BITS];
  assign o_code      = w_c[DAC_BITS-1:0];
`endif

endmodule

// File: rtl/dac_spi_tx.sv
// Filtered-sample to SPI DAC serialiser: code conversion, 16-bit MSB-first frame,
// one-deep pending sample with overwrite flag. Honours DAC_SAT_EN via dac_code_conv.
module dac_spi_tx
  import dac_defs::*;
#(
  parameter int DATA_W  = 25,
  parameter int FRAC_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DATA_W-1:0] y,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdata,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_bit_cnt;
  logic             r_sclk;
  logic             r_sync_n;
  logic             r_busy;
  logic             r_done;
  logic             r_ovr;
  frame_word_t      r_shift;
  logic             r_pend_vld;
  dac_code_t        r_pend_code;

  dac_code_t        w_code;
  dac_code_t        w_start_code;
  logic             w_div_end;
  logic             w_gap_end;
  logic             w_start;
  logic             w_to_pend;

  dac_code_conv #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_conv (
    .i_y    (y),
    .o_code (w_code)
  );

  // A fresh rx at gap end wins over the pending sample it overwrites.
  always_comb begin
    w_div_end    = (r_div_cnt == DIV_LAST);
    w_gap_end    = (r_state == ST_GAP) && w_div_end;
    w_start      = ((r_state == ST_IDLE) && rx) || (w_gap_end && (rx || r_pend_vld));
    w_start_code = rx ? w_code : r_pend_code;
    w_to_pend    = rx && !w_start;
  end

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_sclk      <= 1'b1;
      r_sync_n    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
      r_shift     <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= '0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= rx && r_pend_vld;

      if (w_start) begin
        r_pend_vld <= 1'b0;
      end else if (w_to_pend) begin
        r_pend_vld  <= 1'b1;
        r_pend_code <= w_code;
      end

      if (w_start) begin
        r_state   <= ST_SHIFT;
        r_shift   <= frame_word(w_start_code);
        r_sync_n  <= 1'b0;
        r_busy    <= 1'b1;
        r_sclk    <= 1'b1;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_div_end) begin
              r_div_cnt <= '0;
              if (r_sclk) begin
                r_sclk <= 1'b0;
              end else begin
                // Rising sclk: advance data; the 16th rising edge closes the frame.
                r_sclk  <= 1'b1;
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                if (r_bit_cnt == BIT_LAST) begin
                  r_state  <= ST_GAP;
                  r_sync_n <= 1'b1;
                  r_done   <= 1'b1;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                end
              end
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
          end
          ST_GAP: begin
            if (w_gap_end) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_div_cnt <= '0;
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            r_div_cnt <= '0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sclk   = r_sclk;
  assign sync_n = r_sync_n;
  assign sdata  = r_shift[FRAME_BITS-1];
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovr    = r_ovr;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: table vectors, hand sequences and a random
// run against a transaction-level timing model. Follows DAC_SAT_EN like the RTL.
module tb_dac_spi_tx;

  localparam int DATA_W     = 25;
  localparam int FRAC_W     = 16;
  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 32 * CLK_DIV;
  localparam int PERIOD     = FRAME_CLKS + CLK_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic [DATA_W-1:0] y;
  logic              sclk, sync_n, sdata, busy, done, ovr;

  always #5 clk = ~clk;

  dac_spi_tx #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .y      (y),
    .sclk   (sclk),
    .sync_n (sync_n),
    .sdata  (sdata),
    .busy   (busy),
    .done   (done),
    .ovr    (ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SPI monitor: decodes frames as the DAC would see them
  typedef struct {
    int          start;
    int          stop;
    logic [15:0] word;
    int          low;
    int          nbits;
    bit          done_ok;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit     in_frame  = 0;
  int     done_cnt  = 0;
  int     ovr_cnt   = 0;
  int     bad_done  = 0;
  int     busy_fall = -1;
  logic   p_sync = 1'b1, p_sclk = 1'b1, p_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
    end else begin
      if (p_sync && !sync_n) begin
        in_frame  = 1;
        cur.start = cyc;
        cur.low   = 0;
        cur.nbits = 0;
        cur.word  = '0;
      end
      if (in_frame && !sync_n) begin
        cur.low++;
        if (p_sclk && !sclk) begin
          cur.word = {cur.word[14:0], sdata};
          cur.nbits++;
        end
      end
      if (in_frame && !p_sync && sync_n) begin
        cur.stop    = cyc;
        cur.done_ok = done;
        frames.push_back(cur);
        in_frame = 0;
      end
      if (done) begin
        done_cnt++;
        if (!(!p_sync && sync_n)) bad_done++;
      end
      if (ovr) ovr_cnt++;
      if (p_busy && !busy) busy_fall = cyc;
    end
    p_sync = sync_n;
    p_sclk = sclk;
    p_busy = busy;
  end

  // ---------------- Reference model: frame start times from the frame period
  int          m_free;
  bit          m_pend;
  logic [15:0] m_pcode;
  int          m_ovr;
  int          exp_start[$];
  logic [15:0] exp_word[$];

  function automatic logic [15:0] ref_code(input logic [DATA_W-1:0] v);
    longint sv, q, c;
    longint div;
    div = longint'(1) << (FRAC_W - 11);
    sv  = longint'($signed(v));
    q   = (sv >= 0) ? sv / div : -((-sv + div - 1) / div);
    c   = q + 2048;
`ifdef DAC_SAT_EN
    if (c < 0)    c = 0;
    if (c > 4095) c = 4095;
`else
    c = c & 4095;
`endif
    return 16'(c);
  endfunction

  task automatic model_reset();
    m_free = 0;
    m_pend = 0;
    m_ovr  = 0;
    exp_start.delete();
    exp_word.delete();
  endtask

  task automatic model_flush(input int t);
    if (m_pend && m_free < t) begin
      exp_start.push_back(m_free);
      exp_word.push_back(m_pcode);
      m_free = m_free + PERIOD;
      m_pend = 0;
    end
  endtask

  task automatic model_rx(input int t, input logic [DATA_W-1:0] v);
    logic [15:0] code;
    model_flush(t);
    code = ref_code(v);
    if (m_pend) m_ovr++;
    if (t >= m_free) begin
      m_pend = 0;
      exp_start.push_back(t);
      exp_word.push_back(code);
      m_free = t + PERIOD;
    end else begin
      m_pend  = 1;
      m_pcode = code;
    end
  endtask

  // ---------------- Drivers (called at a negedge)
  task automatic pulse_rx(input logic [DATA_W-1:0] v);
    rx = 1'b1;
    y  = v;
    model_rx(cyc + 1, v);
    @(negedge clk);
    rx = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !sync_n) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, n < 4000, 1);
    idle(4);
  endtask

  task automatic begin_seg(output int fb, output int ob);
    fb = frames.size();
    ob = ovr_cnt;
    model_reset();
  endtask

  task automatic compare_segment(input string tag, input int fb, input int ob);
    int n;
    model_flush(32'h7fffffff);
    check({tag, "_frame_count"}, frames.size() - fb, exp_word.size());
    n = (frames.size() - fb < exp_word.size()) ? frames.size() - fb : exp_word.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_word%0d", tag, i),  frames[fb+i].word,    exp_word[i]);
      check($sformatf("%s_start%0d", tag, i), frames[fb+i].start,   exp_start[i]);
      check($sformatf("%s_low%0d", tag, i),   frames[fb+i].low,     FRAME_CLKS);
      check($sformatf("%s_bits%0d", tag, i),  frames[fb+i].nbits,   16);
      check($sformatf("%s_done%0d", tag, i),  frames[fb+i].done_ok, 1);
    end
    check({tag, "_ovr_count"}, ovr_cnt - ob, m_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"},   sclk,   1);
    check({tag, "_sync_n"}, sync_n, 1);
    check({tag, "_sdata"},  sdata,  0);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_ovr"},    ovr,    0);
  endtask

  typedef struct {
    logic [DATA_W-1:0] y;
    logic [15:0]       word;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int fb, ob, bad, n, t0;

    vecs[0] = '{25'h0008000, 16'h0C00};
    vecs[1] = '{25'h1FF8000, 16'h0400};
`ifdef DAC_SAT_EN
    vecs[2] = '{25'h0010000, 16'h0FFF};
    vecs[7] = '{25'h0FFFFFF, 16'h0FFF};
    vecs[8] = '{25'h1000000, 16'h0000};
`else
    vecs[2] = '{25'h0010000, 16'h0000};
    vecs[7] = '{25'h0FFFFFF, 16'h07FF};
    vecs[8] = '{25'h1000000, 16'h0800};
`endif
    vecs[3] = '{25'h1FF0000, 16'h0000};
    vecs[4] = '{25'h000FFE0, 16'h0FFF};
    vecs[5] = '{25'h1FFFFFF, 16'h07FF};
    vecs[6] = '{25'h000001F, 16'h0800};

    rst = 1'b1;
    rx  = 1'b0;
    y   = '0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (sclk !== 1'b1 || sync_n !== 1'b1 || busy !== 1'b0 || sdata !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check("idle_done", done_cnt, 0);
    check("idle_ovr", ovr_cnt, 0);

    // Mid-scale frame, done pulse and busy tail
    begin_seg(fb, ob);
    n = done_cnt;
    pulse_rx('0);
    wait_idle("zero");
    compare_segment("zero", fb, ob);
    if (frames.size() > fb) begin
      check("zero_word_const", frames[fb].word, 16'h0800);
      check("zero_busy_tail", busy_fall - frames[fb].stop, CLK_DIV);
    end else begin
      check("zero_frame_seen", 0, 1);
    end
    check("zero_done_pulses", done_cnt - n, 1);

    for (int i = 0; i < 9; i++) begin
      begin_seg(fb, ob);
      pulse_rx(vecs[i].y);
      wait_idle($sformatf("vec%0d", i));
      if (frames.size() > fb) check($sformatf("vec%0d_word_const", i), frames[fb].word, vecs[i].word);
      else check($sformatf("vec%0d_frame_seen", i), 0, 1);
      compare_segment($sformatf("vec%0d", i), fb, ob);
    end

    // Four samples 16 clocks apart: 1 sent, 2 and 3 overwritten, 4 sent
    begin_seg(fb, ob);
    pulse_rx(25'd32);  idle(15);
    pulse_rx(25'd64);  idle(15);
    pulse_rx(25'd96);  idle(15);
    pulse_rx(25'd128);
    wait_idle("burst");
    compare_segment("burst", fb, ob);
    check("burst_frames", frames.size() - fb, 2);
    check("burst_ovr", ovr_cnt - ob, 2);
    if (frames.size() >= fb + 2) begin
      check("burst_word0", frames[fb].word, 16'h0801);
      check("burst_word1", frames[fb+1].word, 16'h0804);
      check("burst_gap", frames[fb+1].start - frames[fb].stop, CLK_DIV);
    end

    // rx lands on the last gap cycle while a sample is pending
    begin_seg(fb, ob);
    t0 = cyc + 1;
    pulse_rx(25'd32);  idle(9);
    pulse_rx(25'd64);  idle(PERIOD - 11);
    check("gapend_edge_aligned", cyc + 1 - t0, PERIOD);
    pulse_rx(25'd96);
    wait_idle("gapend");
    compare_segment("gapend", fb, ob);
    if (frames.size() >= fb + 2) begin
      check("gapend_word1", frames[fb+1].word, 16'h0803);
      check("gapend_start1", frames[fb+1].start - frames[fb].start, PERIOD);
    end
    check("gapend_ovr", ovr_cnt - ob, 1);

    // Reset mid-frame with a sample pending
    begin_seg(fb, ob);
    pulse_rx(25'h0008000); idle(5);
    pulse_rx(25'h1FF8000);
    n = 0;
    while (!(in_frame && cur.nbits == 8) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_timeout", n < 500, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    idle(100);
    check("midrst_no_frames", frames.size() - fb, 0);
    begin_seg(fb, ob);
    pulse_rx(25'h1FF8000);
    wait_idle("postrst");
    compare_segment("postrst", fb, ob);
    if (frames.size() > fb) check("postrst_word_const", frames[fb].word, 16'h0400);

    // Random traffic, including back-to-back rx
    begin_seg(fb, ob);
    for (int i = 0; i < 60; i++) begin
      pulse_rx(DATA_W'($urandom));
      idle($urandom_range(0, 90));
    end
    wait_idle("rand");
    compare_segment("rand", fb, ob);

    check("done_only_at_frame_end", bad_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
